// File: rtl/alu_seq_pkg.sv
// Shared constants, state/op enums and decode helpers for the ALU sequencer.
// ALU_SERIAL_SHIFT_EN is consumed by alu_sequencer, not here.
package alu_seq_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR,
    OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA
  } alu_op_e;

  function automatic logic opcode_legal(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
           (opcode == OPC_STORE) || (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
  endfunction

  // Only register/immediate ALU ops look at FUNCT3; everything else adds.
  function automatic alu_op_e decode_op(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic       funct1);
    alu_op_e op;
    op = OP_ADD;
    if ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) begin
      case (funct3)
        F3_ADD:  op = ((opcode == OPC_OP) && funct1) ? OP_SUB : OP_ADD;
        F3_SLL:  op = OP_SLL;
        F3_SLT:  op = OP_SLT;
        F3_SLTU: op = OP_SLTU;
        F3_XOR:  op = OP_XOR;
        F3_SR:   op = funct1 ? OP_SRA : OP_SRL;
        F3_OR:   op = OP_OR;
        F3_AND:  op = OP_AND;
        default: op = OP_ADD;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-step combinational ALU datapath; shifts use data1[4:0] only.
module alu_core
  import alu_seq_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = data1[4:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = data0 + data1;
      OP_SUB:  result = data0 - data1;
      OP_SLT:  result = {31'b0, $signed(data0) < $signed(data1)};
      OP_SLTU: result = {31'b0, data0 < data1};
      OP_XOR:  result = data0 ^ data1;
      OP_OR:   result = data0 | data1;
      OP_AND:  result = data0 & data1;
      OP_SLL:  result = data0 << shamt;
      OP_SRL:  result = data0 >> shamt;
      OP_SRA:  result = $signed(data0) >>> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Handshaked ALU sequencer: IDLE -> (SHIFT) -> DONE. ALU_SERIAL_SHIFT_EN enables
// bit-serial shifts through SHIFT; otherwise every op completes in one cycle.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic        FUNCT1,
  input  logic [4:0]  RS2,
  input  logic [11:0] IMM12,
  input  logic [19:0] U_IMM20,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] PC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] RESULT,
  output logic        ILLEGAL,
  input  logic        FLUSH,
  output logic        BUSY,
  output alu_state_e  state_dbg
);

  // Handshakes: a transfer happens on a CLK edge where valid and ready are both high.
  alu_state_e  state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        illegal_q, illegal_d;
  logic [31:0] data0, data1, core_a, core_b, core_y;
  alu_op_e     dec_op, core_op;
  logic        legal, accept;
  logic        unused_rs2;

`ifdef ALU_SERIAL_SHIFT_EN
  alu_op_e     op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
`endif

  assign unused_rs2 = ^RS2;
  assign dec_op     = decode_op(OPCODE, FUNCT3, FUNCT1);
  assign legal      = opcode_legal(OPCODE);
  assign IN_READY   = RST_N && (state_q == ST_IDLE) && !FLUSH;
  assign accept     = IN_VALID && IN_READY;
  assign OUT_VALID  = (state_q == ST_DONE);
  assign BUSY       = (state_q != ST_IDLE);
  assign RESULT     = result_q;
  assign ILLEGAL    = illegal_q;
  assign state_dbg  = state_q;

  always_comb begin
    data0 = RS1_DATA;
    if (OPCODE == OPC_AUIPC)    data0 = PC;
    else if (OPCODE == OPC_LUI) data0 = '0;
    case (OPCODE)
      OPC_OP:                          data1 = RS2_DATA;
      OPC_LUI, OPC_AUIPC:              data1 = {U_IMM20, 12'b0};
      OPC_OP_IMM, OPC_LOAD, OPC_STORE: data1 = {{20{IMM12[11]}}, IMM12};
      default:                         data1 = '0;
    endcase
  end

  // In SHIFT the core is reused as a one-bit shifter on the accumulator.
  always_comb begin
    core_op = dec_op;
    core_a  = data0;
    core_b  = data1;
`ifdef ALU_SERIAL_SHIFT_EN
    if (state_q == ST_SHIFT) begin
      core_op = op_q;
      core_a  = result_q;
      core_b  = 32'd1;
    end
`endif
  end

  alu_core u_core (
    .op     (core_op),
    .data0  (core_a),
    .data1  (core_b),
    .result (core_y)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ALU_SERIAL_SHIFT_EN
    op_d  = op_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          illegal_d = !legal;
          result_d  = legal ? core_y : '0;
          state_d   = ST_DONE;
`ifdef ALU_SERIAL_SHIFT_EN
          if (legal && is_shift_op(dec_op) && (data1[4:0] != 5'd0)) begin
            result_d = data0;
            op_d     = dec_op;
            cnt_d    = data1[4:0];
            state_d  = ST_SHIFT;
          end
`endif
        end
      end
      ST_SHIFT: begin
`ifdef ALU_SERIAL_SHIFT_EN
        if (cnt_q == 5'd0) begin
          state_d = ST_DONE;
        end else begin
          result_d = core_y;
          cnt_d    = cnt_q - 5'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (FLUSH) begin
      state_d = ST_IDLE;
`ifdef ALU_SERIAL_SHIFT_EN
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      op_q  <= OP_ADD;
      cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef ALU_SERIAL_SHIFT_EN
      op_q  <= op_d;
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed table-driven bench for alu_sequencer plus hand sequences for
// backpressure, flush and reset corner cases.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct1;
  logic [4:0]  rs2;
  logic [11:0] imm12;
  logic [19:0] u_imm20;
  logic [31:0] rs1_data, rs2_data, pc;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        illegal;
  logic        flush, busy;
  alu_state_e  state_dbg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct1;
    logic [11:0] imm12;
    logic [19:0] u_imm20;
    logic [31:0] rs1, rs2, pc;
    logic [31:0] exp_res;
    logic        exp_ill;
    int          shamt;
  } vec_t;

  vec_t vecs[21];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OPCODE(opcode), .FUNCT3(funct3), .FUNCT1(funct1), .RS2(rs2),
    .IMM12(imm12), .U_IMM20(u_imm20), .RS1_DATA(rs1_data), .RS2_DATA(rs2_data),
    .PC(pc), .OUT_VALID(out_valid), .OUT_READY(out_ready), .RESULT(result),
    .ILLEGAL(illegal), .FLUSH(flush), .BUSY(busy), .state_dbg(state_dbg)
  );

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                              input logic [11:0] imm, input logic [19:0] uimm,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                              input logic [31:0] er, input logic ei, input int sh);
    vec_t v;
    v.opcode = op; v.funct3 = f3; v.funct1 = f1; v.imm12 = imm; v.u_imm20 = uimm;
    v.rs1 = a; v.rs2 = b; v.pc = p; v.exp_res = er; v.exp_ill = ei; v.shamt = sh;
    return v;
  endfunction

  function automatic int exp_latency(input int sh);
`ifdef ALU_SERIAL_SHIFT_EN
    return 1 + sh;
`else
    return (sh >= 0) ? 1 : 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    @(negedge clk);
    opcode = v.opcode; funct3 = v.funct3; funct1 = v.funct1; imm12 = v.imm12;
    u_imm20 = v.u_imm20; rs1_data = v.rs1; rs2_data = v.rs2; pc = v.pc;
    rs2 = 5'($urandom_range(0, 31));
    in_valid = 1'b1;
    check("in_ready_before_transfer", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the transfer edge until OUT_VALID; 0 means it never came.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_drain", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic count_quiet(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    int lat;
    vec_t v;
    vecs[0]  = mk(OPC_OP,     3'b000, 1'b0, 12'h000, 20'h0, 32'd5,        32'd7,        0, 32'd12,        1'b0, 0);
    vecs[1]  = mk(OPC_OP,     3'b000, 1'b1, 12'h000, 20'h0, 32'd5,        32'd7,        0, 32'hFFFFFFFE,  1'b0, 0);
    vecs[2]  = mk(OPC_OP_IMM, 3'b000, 1'b0, 12'h001, 20'h0, 32'hFFFFFFFF, 32'd0,        0, 32'h0,         1'b0, 0);
    vecs[3]  = mk(OPC_OP_IMM, 3'b000, 1'b0, 12'hFFF, 20'h0, 32'h0,        32'd0,        0, 32'hFFFFFFFF,  1'b0, 0);
    vecs[4]  = mk(OPC_OP_IMM, 3'b000, 1'b1, 12'h001, 20'h0, 32'h10,       32'd0,        0, 32'h11,        1'b0, 0);
    vecs[5]  = mk(OPC_OP,     3'b010, 1'b0, 12'h000, 20'h0, 32'hFFFFFFFF, 32'd1,        0, 32'd1,         1'b0, 0);
    vecs[6]  = mk(OPC_OP,     3'b011, 1'b0, 12'h000, 20'h0, 32'hFFFFFFFF, 32'd1,        0, 32'd0,         1'b0, 0);
    vecs[7]  = mk(OPC_OP_IMM, 3'b010, 1'b0, 12'hFFF, 20'h0, 32'd5,        32'd0,        0, 32'd0,         1'b0, 0);
    vecs[8]  = mk(OPC_OP_IMM, 3'b011, 1'b0, 12'hFFF, 20'h0, 32'd5,        32'd0,        0, 32'd1,         1'b0, 0);
    vecs[9]  = mk(OPC_OP,     3'b100, 1'b0, 12'h000, 20'h0, 32'h0F0F0F0F, 32'hFFFF0000, 0, 32'hF0F00F0F,  1'b0, 0);
    vecs[10] = mk(OPC_OP_IMM, 3'b110, 1'b0, 12'h0FF, 20'h0, 32'h100,      32'd0,        0, 32'h1FF,       1'b0, 0);
    vecs[11] = mk(OPC_OP,     3'b111, 1'b0, 12'h000, 20'h0, 32'hFF00FF00, 32'h0F0F0F0F, 0, 32'h0F000F00,  1'b0, 0);
    vecs[12] = mk(OPC_OP,     3'b001, 1'b0, 12'h000, 20'h0, 32'h1,        32'h24,       0, 32'h10,        1'b0, 4);
    vecs[13] = mk(OPC_OP_IMM, 3'b101, 1'b0, 12'h004, 20'h0, 32'h80000000, 32'd0,        0, 32'h08000000,  1'b0, 4);
    vecs[14] = mk(OPC_OP_IMM, 3'b101, 1'b1, 12'h41F, 20'h0, 32'h80000000, 32'd0,        0, 32'hFFFFFFFF,  1'b0, 31);
    vecs[15] = mk(OPC_OP,     3'b101, 1'b1, 12'h000, 20'h0, 32'h40000000, 32'd3,        0, 32'h08000000,  1'b0, 3);
    vecs[16] = mk(OPC_OP,     3'b001, 1'b0, 12'h000, 20'h0, 32'h1234,     32'h20,       0, 32'h1234,      1'b0, 0);
    vecs[17] = mk(OPC_LUI,    3'b011, 1'b0, 12'h000, 20'h12345, 32'hDEADBEEF, 32'd0,    0, 32'h12345000,  1'b0, 0);
    vecs[18] = mk(OPC_LOAD,   3'b010, 1'b0, 12'hFFC, 20'h0, 32'h1000,     32'd0,        0, 32'hFFC,       1'b0, 0);
    vecs[19] = mk(OPC_STORE,  3'b010, 1'b0, 12'h010, 20'h0, 32'h2000,     32'd0,        0, 32'h2010,      1'b0, 0);
    vecs[20] = mk(7'b1111111, 3'b000, 1'b0, 12'h000, 20'h0, 32'd5,        32'd7,        0, 32'h0,         1'b1, 0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    opcode = '0; funct3 = '0; funct1 = 1'b0; rs2 = '0; imm12 = '0; u_imm20 = '0;
    rs1_data = '0; rs2_data = '0; pc = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_illegal", {31'b0, illegal}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 21; i++) begin
      send(vecs[i]);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].shamt));
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].exp_ill});
      drain();
    end

    // AUIPC held under backpressure.
    v = mk(OPC_AUIPC, 3'b000, 1'b0, 12'h000, 20'h00002, 32'h55, 32'd0, 32'h1000, 32'h3000, 1'b0, 0);
    send(v);
    wait_out(lat);
    check("auipc_latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_result_stable", result, 32'h3000);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    drain();
    check("bp_in_ready_after_drain", {31'b0, in_ready}, 32'd1);

    // Flush four edges into a 10-bit shift.
    v = mk(OPC_OP, 3'b001, 1'b0, 12'h000, 20'h0, 32'h1, 32'd10, 0, 32'h400, 1'b0, 10);
    send(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_state_idle", {30'b0, state_dbg}, {30'b0, ST_IDLE});
    #1;
    check("flush_in_ready_next", {31'b0, in_ready}, 32'd1);
    count_quiet(15, "flush_no_output");

    // Reset in the middle of a long shift.
    send(vecs[14]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    count_quiet(40, "rst_mid_no_output");

    // Post-reset sanity transaction.
    send(vecs[0]);
    wait_out(lat);
    check("post_rst_latency", lat, 1);
    check("post_rst_result", result, 32'd12);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, all state on rising edge. RST_N  in  1  reset; one clock; reset is synchronous and active-low.
REQ-002 SHALL have ports: IN_VALID in 1, IN_READY out 1: instruction handshake; transfer when both high on a CLK edge.
REQ-003 SHALL have ports: OPCODE in 7, FUNCT3 in 3, FUNCT1 in 1 (instr bit 30), RS2 in 5, IMM12 in 12, U_IMM20 in 20, RS1_DATA in 32, RS2_DATA in 32, PC in 32: decoded instruction fields.
REQ-004 SHALL have ports: OUT_VALID out 1, OUT_READY in 1, RESULT out 32, ILLEGAL out 1: result handshake; RESULT/ILLEGAL valid while OUT_VALID.
REQ-005 SHALL have ports: FLUSH in 1 (abort in-flight op), BUSY out 1 (high in any state except IDLE).

Function
REQ-006 Operand select SHALL be: DATA0 = PC for 0010111, 0 for 0110111, else RS1_DATA; DATA1 = RS2_DATA for 0110011, {U_IMM20,12'b0} for 0110111/0010111, sign-extended IMM12 for 0010011/0000011/0100011.
REQ-007 Operations SHALL be by FUNCT3: 000 add (sub if OPCODE 0110011 and FUNCT1), 010 signed SLT, 011 unsigned SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL (SRA if FUNCT1); SLT/SLTU results 32'd1/32'd0.
REQ-008 Loads, stores, LUI, AUIPC SHALL add, ignoring FUNCT3; all arithmetic is 32-bit modulo 2^32, overflow ignored.
REQ-009 Shift amount SHALL be DATA1[4:0]; upper bits ignored.
REQ-010 Any other OPCODE SHALL be accepted and complete with RESULT=0, ILLEGAL=1; legal ops complete with ILLEGAL=0.
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE. IN_READY = 1 only in IDLE and not FLUSH.
REQ-012 IDLE: on transfer, latch operands and op; go SHIFT if serial shift applies and shamt>0, else compute result and go DONE.
REQ-013 SHIFT: shift accumulator by 1 bit per cycle, decrement counter; on counter reaching 0 go DONE.
REQ-014 DONE: OUT_VALID=1; RESULT/ILLEGAL held stable until OUT_READY; on OUT_READY go IDLE (no accept in same cycle).
REQ-015 Latency: transfer at edge N -> OUT_VALID at N+1 for non-serial ops; N+1+shamt for serial shifts.
REQ-016 FLUSH SHALL take priority over everything: next state IDLE, OUT_VALID low next cycle, in-flight result discarded, no transfer in a FLUSH cycle.

Reset
REQ-017 RST_N low at an edge SHALL force IDLE, OUT_VALID=0, RESULT=0, ILLEGAL=0, shift counter=0, regardless of state; IN_READY=0 while RST_N low.
REQ-018 Reset mid-SHIFT or mid-DONE SHALL discard the op with no output.

Configuration
REQ-019 Macro ALU_SERIAL_SHIFT_EN defined: shifts use SHIFT state per REQ-013. Undefined: SHIFT state unreachable, all shifts single-cycle (latency 1), no shift counter.
REQ-020 Results SHALL be bit-identical with and without the macro.

Structure
REQ-021 Package alu_seq_pkg SHALL hold opcode constants, FUNCT3 constants and the state enum type.
REQ-022 Combinational single-step datapath SHALL be sub-module alu_core (ops, DATA0/DATA1 in, result out); alu_sequencer owns FSM, registers, handshakes.

Verification
REQ-023 ADD: OPCODE 0110011, FUNCT3 000, FUNCT1 0, RS1=5, RS2=7 -> OUT_VALID one cycle later, RESULT=12, ILLEGAL=0.
REQ-024 ADDI wrap: OPCODE 0010011, RS1=32'hFFFFFFFF, IMM12=12'h001 -> RESULT=0; IMM12=12'hFFF, RS1=0 -> RESULT=32'hFFFFFFFF.
REQ-025 SRAI serial (macro on): RS1=32'h80000000, IMM12=12'h41F (FUNCT1=1, shamt 31) -> OUT_VALID exactly 32 cycles after transfer, RESULT=32'hFFFFFFFF; macro off -> 1 cycle, same RESULT.
REQ-026 Backpressure/AUIPC: PC=32'h1000, U_IMM20=20'h00002, OUT_READY low 5 cycles -> RESULT=32'h3000 held stable, IN_READY=0 until drained.
REQ-027 FLUSH during SHIFT (shamt 10, FLUSH at cycle 3) -> no OUT_VALID, IDLE and IN_READY=1 next cycle; OPCODE 1111111 -> RESULT=0, ILLEGAL=1.
